// File: rtl/print.sv
// Debug print engine: turns a 32-bit value into a raw byte or an uppercase hex string on a valid/ready byte stream.
// Optional macro PRINT_CRLF_EN appends CR LF after every hex string.
//
// state | meaning
// IDLE  | waiting for a rising edge on req_tx
// SEND  | presenting d_tx with vld_tx until the transmitter takes it
// DONE  | one-cycle ack_tx pulse, then back to IDLE
module print #(
    parameter int HEX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dout_tx,
    input  logic        type_tx,
    input  logic        req_tx,
    output logic        ack_tx,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx
);

    localparam int TOP = 4 * HEX_DIGITS - 1;
`ifdef PRINT_CRLF_EN
    localparam logic [3:0] HEX_CNT = 4'(HEX_DIGITS + 2);
`else
    localparam logic [3:0] HEX_CNT = 4'(HEX_DIGITS);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_prev_q;
    logic [31:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  d_q, d_d;
    logic        start;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return {4'h0, n} + ((n < 4'd10) ? 8'h30 : 8'h37);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_prev_q <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            d_q        <= '0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= req_tx;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            d_q        <= d_d;
        end
    end

    assign start = req_tx & ~req_prev_q;

    // cnt_q holds the characters still to transfer, including the one on d_tx.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    if (type_tx) begin
                        d_d    = hex_ascii(dout_tx[TOP -: 4]);
                        data_d = dout_tx << 4;
                        cnt_d  = HEX_CNT;
                    end else begin
                        d_d    = dout_tx[7:0];
                        data_d = dout_tx;
                        cnt_d  = 4'd1;
                    end
                end
            end
            SEND: begin
                if (rdy_tx) begin
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d  = cnt_q - 4'd1;
                        data_d = data_q << 4;
`ifdef PRINT_CRLF_EN
                        if (cnt_q == 4'd3) begin
                            d_d = 8'h0D;
                        end else if (cnt_q == 4'd2) begin
                            d_d = 8'h0A;
                        end else begin
                            d_d = hex_ascii(data_q[TOP -: 4]);
                        end
`else
                        d_d = hex_ascii(data_q[TOP -: 4]);
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vld_tx = (state_q == SEND);
    assign ack_tx = (state_q == DONE);
    assign d_tx   = d_q;

endmodule

// File: tb/tb_print.sv
// Self-checking bench for print: queue-based string model compared every cycle, plus literal string checks.
module tb_print;

    localparam int HEX_DIGITS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dout_tx = '0;
    logic        type_tx = 1'b0;
    logic        req_tx = 1'b0;
    logic        rdy_tx = 1'b1;
    logic        ack_tx;
    logic [7:0]  d_tx;
    logic        vld_tx;

    int checks = 0;
    int errors = 0;

    print #(.HEX_DIGITS(HEX_DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .dout_tx (dout_tx),
        .type_tx (type_tx),
        .req_tx  (req_tx),
        .ack_tx  (ack_tx),
        .d_tx    (d_tx),
        .vld_tx  (vld_tx),
        .rdy_tx  (rdy_tx)
    );

    always #5 clk = ~clk;

    // Behavioural model: a print is just a queue of bytes drained by handshakes.
    logic [7:0] mq[$];
    logic       m_prev = 1'b0;
    logic       m_vld = 1'b0;
    logic       m_ack = 1'b0;
    logic [7:0] m_d = 8'h00;

    function automatic logic [7:0] to_hex_char(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    task automatic build(input logic t, input logic [31:0] v);
        if (!t) begin
            mq.push_back(v[7:0]);
        end else begin
            for (int i = 0; i < HEX_DIGITS; i++)
                mq.push_back(to_hex_char(int'((v >> (4 * (HEX_DIGITS - 1 - i))) & 32'hF)));
`ifdef PRINT_CRLF_EN
            mq.push_back(8'h0D);
            mq.push_back(8'h0A);
`endif
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_prev = 1'b0;
            m_vld  = 1'b0;
            m_ack  = 1'b0;
            m_d    = 8'h00;
        end else begin
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (mq.size() > 0) begin
                if (rdy_tx) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_ack = 1'b1;
                end
            end else if (req_tx && !m_prev) begin
                build(type_tx, dout_tx);
            end
            m_prev = req_tx;
            m_vld  = (mq.size() > 0);
            if (m_vld) m_d = mq[0];
        end
    end

    // Per-cycle compare and capture of transferred bytes
    logic [7:0] cap[$];
    int         ack_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (vld_tx !== m_vld || ack_tx !== m_ack || d_tx !== m_d) begin
                errors++;
                $display("FAIL cycle_model t=%0t: vld=%b ack=%b d=%h, required vld=%b ack=%b d=%h",
                         $time, vld_tx, ack_tx, d_tx, m_vld, m_ack, m_d);
            end
            if (vld_tx && rdy_tx) cap.push_back(d_tx);
            if (ack_tx) ack_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input string name, input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && ack_cnt < target; i++) tick();
        checks++;
        if (ack_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: ack count %0d, required %0d", name, ack_cnt, target);
        end
    endtask

    task automatic check_str(input string name, input string s, input logic hex);
        logic [7:0] exp[$];
        for (int i = 0; i < s.len(); i++) exp.push_back(8'(s[i]));
`ifdef PRINT_CRLF_EN
        if (hex) begin
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
        end
`endif
        chk({name, "_len"}, 32'(cap.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk({name, "_byte"}, {24'h0, cap[i]}, {24'h0, exp[i]});
    endtask

    task automatic do_print(input string name, input logic t, input logic [31:0] v,
                            input int hold, input string s);
        int a0;
        cap.delete();
        a0 = ack_cnt;
        dout_tx = v;
        type_tx = t;
        req_tx  = 1'b1;
        repeat (hold) tick();
        req_tx = 1'b0;
        wait_ack(name, a0 + 1, 100);
        repeat (4) tick();
        chk({name, "_acks"}, 32'(ack_cnt - a0), 32'd1);
        check_str(name, s, t);
    endtask

    initial begin
        int a0;
        rdy_tx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vld", {31'h0, vld_tx}, 32'h0);
        chk("reset_ack", {31'h0, ack_tx}, 32'h0);
        chk("reset_d", {24'h0, d_tx}, 32'h0);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // raw character, request held several cycles
        do_print("raw31", 1'b0, 32'h0000_0031, 5, "1");
        do_print("hex12AB00FF", 1'b1, 32'h12AB_00FF, 2, "12AB00FF");

        // back-pressure on second character
        cap.delete();
        a0 = ack_cnt;
        dout_tx = 32'hDEAD_BEEF;
        type_tx = 1'b1;
        req_tx  = 1'b1;
        tick();
        tick();
        rdy_tx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_vld", {31'h0, vld_tx}, 32'h1);
            chk("stall_d", {24'h0, d_tx}, 32'h45);
            tick();
        end
        rdy_tx = 1'b1;
        req_tx = 1'b0;
        wait_ack("deadbeef", a0 + 1, 100);
        repeat (3) tick();
        check_str("deadbeef", "DEADBEEF", 1'b1);

        // busy: request toggles and input changes mid-print
        cap.delete();
        a0 = ack_cnt;
        dout_tx = 32'hA5C3_7E19;
        type_tx = 1'b1;
        req_tx  = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            req_tx  = ~req_tx;
            dout_tx = $urandom;
            type_tx = 1'($urandom_range(0, 1));
            tick();
        end
        req_tx = 1'b1;
        wait_ack("busy", a0 + 1, 100);
        repeat (4) tick();
        req_tx = 1'b0;
        repeat (4) tick();
        chk("busy_acks", 32'(ack_cnt - a0), 32'd1);
        check_str("busy", "A5C37E19", 1'b1);

        // reset mid-print
        cap.delete();
        a0 = ack_cnt;
        dout_tx = 32'h1357_9BDF;
        type_tx = 1'b1;
        req_tx  = 1'b1;
        for (int i = 0; i < 50 && cap.size() < 3; i++) @(negedge clk);
        chk("rst_mid_reached", 32'(cap.size()), 32'd3);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_mid_vld", {31'h0, vld_tx}, 32'h0);
        chk("rst_mid_ack", {31'h0, ack_tx}, 32'h0);
        chk("rst_mid_d", {24'h0, d_tx}, 32'h0);
        req_tx = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_mid_no_ack", 32'(ack_cnt - a0), 32'd0);

        do_print("zeros", 1'b1, 32'h0000_0000, 1, "00000000");
        do_print("ones", 1'b1, 32'hFFFF_FFFF, 1, "FFFFFFFF");
        do_print("raw_after", 1'b0, 32'hCAFE_BA7E, 1, "~");

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rdy_tx = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) req_tx = ~req_tx;
            dout_tx = $urandom;
            type_tx = 1'($urandom_range(0, 1));
            tick();
        end
        rdy_tx = 1'b1;
        req_tx = 1'b0;
        repeat (30) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
